// File: rtl/jk_step_controller.sv
// Step sequencer for the two-bit JK state machine: conditions SW0/BTN0/V and issues one-cycle TICKs.
// Define STEP_LIMIT_EN to enable the RUN-mode step budget (STEP_LIMIT ticks, then auto-pause).
module jk_step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RATE_CYCLES     = 50000000
`ifdef STEP_LIMIT_EN
    ,
    parameter int STEP_LIMIT      = 16
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SW0,
    input  logic       BTN0,
    input  logic       V,
    output logic       TICK,
    output logic       V_HOLD,
    output logic [7:0] STEP_COUNT,
    output logic       RUN_LED,
    output logic       PAUSE_LED
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RATE_W = $clog2(RATE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RATE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_MANUAL,
        S_RUN,
        S_PAUSE
    } state_t;

    state_t state;
    state_t state_next;

    logic sw_meta, sw_sync, sw_prev;
    logic btn_meta, btn_sync;
    logic v_meta, v_sync;
    logic [DB_W-1:0] db_count;
    logic btn_db, btn_db_prev;
    logic [RATE_W-1:0] rate_count, rate_next;
    logic press, sw_rise, sw_fall, terminal, step_evt, limit_hit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_meta  <= 1'b0;
            sw_sync  <= 1'b0;
            sw_prev  <= 1'b0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            v_meta   <= 1'b0;
            v_sync   <= 1'b0;
        end else begin
            sw_meta  <= SW0;
            sw_sync  <= sw_meta;
            sw_prev  <= sw_sync;
            btn_meta <= BTN0;
            btn_sync <= btn_meta;
            v_meta   <= V;
            v_sync   <= v_meta;
        end
    end

    // The debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            db_count    <= '0;
            btn_db      <= 1'b0;
            btn_db_prev <= 1'b0;
        end else begin
            btn_db_prev <= btn_db;
            if (btn_sync == btn_db) begin
                db_count <= '0;
            end else if (db_count == DB_LAST) begin
                btn_db   <= btn_sync;
                db_count <= '0;
            end else begin
                db_count <= db_count + 1'b1;
            end
        end
    end

    assign press    = btn_db & ~btn_db_prev;
    assign sw_rise  = sw_sync & ~sw_prev;
    assign sw_fall  = ~sw_sync & sw_prev;
    assign terminal = (rate_count == RATE_LAST);

`ifdef STEP_LIMIT_EN
    logic [7:0] run_steps;

    // Budget restarts on every entry to S_RUN, so a resume always gets a full STEP_LIMIT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            run_steps <= '0;
        end else if (state != S_RUN && state_next == S_RUN) begin
            run_steps <= '0;
        end else if (state == S_RUN && TICK) begin
            run_steps <= run_steps + 1'b1;
        end
    end

    assign limit_hit = (state == S_RUN) && TICK && (run_steps == 8'(STEP_LIMIT - 1));
`else
    assign limit_hit = 1'b0;
`endif

    // Switch edges outrank PRESS, and any exit from S_RUN suppresses a coincident terminal count.
    always_comb begin
        state_next = state;
        rate_next  = rate_count;
        step_evt   = 1'b0;
        unique case (state)
            S_MANUAL: begin
                if (sw_rise) begin
                    state_next = S_RUN;
                    rate_next  = '0;
                end else if (!sw_fall) begin
                    step_evt = press;
                end
            end
            S_RUN: begin
                if (sw_fall) begin
                    state_next = S_MANUAL;
                end else if (press || limit_hit) begin
                    state_next = S_PAUSE;
                end else begin
                    step_evt  = terminal;
                    rate_next = terminal ? '0 : rate_count + 1'b1;
                end
            end
            S_PAUSE: begin
                if (sw_fall) begin
                    state_next = S_MANUAL;
                end else if (press) begin
                    state_next = S_RUN;
                    rate_next  = '0;
                end
            end
            default: begin
                state_next = S_MANUAL;
                rate_next  = '0;
            end
        endcase
    end

    // A LOAD always yields its TICK on the following cycle, whatever the FSM does meanwhile.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_MANUAL;
            rate_count <= '0;
            TICK       <= 1'b0;
            V_HOLD     <= 1'b0;
            STEP_COUNT <= '0;
            RUN_LED    <= 1'b0;
            PAUSE_LED  <= 1'b0;
        end else begin
            state      <= state_next;
            rate_count <= rate_next;
            TICK       <= step_evt;
            if (step_evt) begin
                V_HOLD <= v_sync;
            end
            if (TICK) begin
                STEP_COUNT <= STEP_COUNT + 1'b1;
            end
            RUN_LED   <= (state_next == S_RUN);
            PAUSE_LED <= (state_next == S_PAUSE);
        end
    end

endmodule

// File: tb/tb_jk_step_controller.sv
// Directed bench for jk_step_controller with DEBOUNCE_CYCLES=4, RATE_CYCLES=10, STEP_LIMIT=3.
// Expected counts for the run-budget scenarios depend on whether STEP_LIMIT_EN is defined.
module tb_jk_step_controller;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SW0 = 1'b0;
    logic       BTN0 = 1'b0;
    logic       V = 1'b0;
    logic       TICK;
    logic       V_HOLD;
    logic [7:0] STEP_COUNT;
    logic       RUN_LED;
    logic       PAUSE_LED;

    int compares = 0;
    int fails = 0;
    int cyc = 0;
    int tick_total = 0;
    int last_tick = -100;
    int tick_q[$];

`ifdef STEP_LIMIT_EN
    localparam int AUTO_TICKS  = 3;
    localparam int LONG_TICKS  = 3;
`else
    localparam int AUTO_TICKS  = 4;
    localparam int LONG_TICKS  = 5;
`endif

    typedef struct {
        logic       v;
        int         hold;
        int         gap;
        int         exp_ticks;
        logic       exp_vhold;
        logic [7:0] exp_count;
    } vec_t;

    vec_t vecs[8];

    jk_step_controller #(
        .DEBOUNCE_CYCLES(4),
        .RATE_CYCLES(10)
`ifdef STEP_LIMIT_EN
        ,
        .STEP_LIMIT(3)
`endif
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .SW0(SW0),
        .BTN0(BTN0),
        .V(V),
        .TICK(TICK),
        .V_HOLD(V_HOLD),
        .STEP_COUNT(STEP_COUNT),
        .RUN_LED(RUN_LED),
        .PAUSE_LED(PAUSE_LED)
    );

    always #5 CLK = ~CLK;

    // Advance n cycles, sampling just after each falling edge and logging TICKs.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
            cyc++;
            if (TICK === 1'b1) begin
                tick_total++;
                last_tick = cyc;
                tick_q.push_back(cyc);
            end
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compares++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        compares++;
        if (actual < lo || actual > hi) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        step(2);
        RST = 1'b0;
        step(2);
    endtask

    // Press BTN0 for hold cycles with V=v, then idle; V is flipped afterwards so V_HOLD must not follow.
    task automatic apply_stimulus(input logic v, input int hold, input int gap, output int press_cyc);
        V = v;
        step(3);
        press_cyc = cyc;
        BTN0 = 1'b1;
        step(hold);
        BTN0 = 1'b0;
        step(gap);
        V = ~v;
        step(4);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int press_cyc;
        int c0;
        int r;
        int gap;
        logic [7:0] wrap_exp[3];

        vecs[0] = '{1'b0, 1,  3,  0, 1'b0, 8'd0};
        vecs[1] = '{1'b0, 2,  3,  0, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 3,  3,  0, 1'b0, 8'd0};
        vecs[3] = '{1'b0, 1,  3,  0, 1'b0, 8'd0};
        vecs[4] = '{1'b0, 3,  3,  0, 1'b0, 8'd0};
        vecs[5] = '{1'b1, 20, 14, 1, 1'b1, 8'd1};
        vecs[6] = '{1'b0, 20, 14, 1, 1'b0, 8'd2};
        vecs[7] = '{1'b1, 4,  14, 1, 1'b1, 8'd3};
        wrap_exp[0] = 8'd255;
        wrap_exp[1] = 8'd0;
        wrap_exp[2] = 8'd1;

        RST = 1'b1;
        step(2);
        check_output("reset_outputs", 32'({TICK, V_HOLD, STEP_COUNT, RUN_LED, PAUSE_LED}), 32'd0);
        RST = 1'b0;
        step(2);

        // Bounce glitches first, then clean presses (the last one exactly DEBOUNCE_CYCLES long).
        for (int i = 0; i < 8; i++) begin
            base = tick_total;
            apply_stimulus(vecs[i].v, vecs[i].hold, vecs[i].gap, press_cyc);
            check_output($sformatf("row%0d_ticks", i), 32'(tick_total - base), 32'(vecs[i].exp_ticks));
            check_output($sformatf("row%0d_vhold", i), 32'(V_HOLD), 32'(vecs[i].exp_vhold));
            check_output($sformatf("row%0d_count", i), 32'(STEP_COUNT), 32'(vecs[i].exp_count));
            if (vecs[i].exp_ticks == 1) begin
                check_range($sformatf("row%0d_latency", i), last_tick - press_cyc, 6, 9);
            end
        end

        // Auto-run from manual mode.
        SW0 = 1'b0;
        apply_reset();
        tick_q.delete();
        c0 = cyc;
        SW0 = 1'b1;
        step(5);
        check_output("auto_run_led", 32'(RUN_LED), 32'd1);
        step(40);
        check_output("auto_tick_count", 32'(tick_q.size()), 32'(AUTO_TICKS));
        check_range("auto_first_tick", (tick_q.size() >= 1) ? tick_q[0] - c0 : -1, 12, 14);
        gap = (tick_q.size() >= 2) ? tick_q[1] - tick_q[0] : -1;
        check_output("auto_period_1", 32'(gap), 32'd10);
        gap = (tick_q.size() >= 3) ? tick_q[2] - tick_q[1] : -1;
        check_output("auto_period_2", 32'(gap), 32'd10);

        // Pause and resume.
        SW0 = 1'b0;
        apply_reset();
        base = tick_total;
        SW0 = 1'b1;
        for (int i = 0; i < 20 && tick_total == base; i++) step(1);
        BTN0 = 1'b1;
        for (int i = 0; i < 20 && PAUSE_LED !== 1'b1; i++) step(1);
        BTN0 = 1'b0;
        check_output("pause_led", 32'(PAUSE_LED), 32'd1);
        base = tick_total;
        step(50);
        check_output("pause_no_ticks", 32'(tick_total - base), 32'd0);
        check_output("pause_run_led", 32'(RUN_LED), 32'd0);
        BTN0 = 1'b1;
        for (int i = 0; i < 20 && RUN_LED !== 1'b1; i++) step(1);
        r = cyc;
        BTN0 = 1'b0;
        base = tick_total;
        for (int i = 0; i < 30 && tick_total == base; i++) step(1);
        // RUN_LED is first seen one cycle after the resume decision; the TICK follows 11 cycles after that decision.
        check_output("resume_first_tick", 32'(last_tick - (r - 1)), 32'd11);

        // SW0 falling on the same cycle as the second terminal count suppresses that step.
        SW0 = 1'b0;
        apply_reset();
        base = tick_total;
        SW0 = 1'b1;
        for (int i = 0; i < 20 && tick_total == base; i++) step(1);
        step(7);
        SW0 = 1'b0;
        step(15);
        check_output("sw_fall_ticks", 32'(tick_total - base), 32'd1);
        check_output("sw_fall_leds", 32'({RUN_LED, PAUSE_LED}), 32'd0);

        // STEP_COUNT wraps 255 -> 0.
        apply_reset();
        for (int i = 0; i < 254; i++) apply_stimulus(1'b1, 6, 8, press_cyc);
        check_output("preload_count", 32'(STEP_COUNT), 32'd254);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 6, 8, press_cyc);
            check_output($sformatf("wrap_count%0d", i), 32'(STEP_COUNT), 32'(wrap_exp[i]));
        end

        // Reset sampled on the LOAD cycle: the pending TICK must vanish.
        V = 1'b1;
        step(3);
        base = tick_total;
        BTN0 = 1'b1;
        step(6);
        RST = 1'b1;
        BTN0 = 1'b0;
        step(1);
        check_output("rst_load_tick", 32'(TICK), 32'd0);
        step(1);
        RST = 1'b0;
        step(20);
        check_output("rst_load_no_ticks", 32'(tick_total - base), 32'd0);
        check_output("rst_load_outputs", 32'({TICK, V_HOLD, STEP_COUNT, RUN_LED, PAUSE_LED}), 32'd0);

        // Button held through reset yields exactly one step afterwards.
        base = tick_total;
        BTN0 = 1'b1;
        apply_reset();
        step(20);
        BTN0 = 1'b0;
        step(12);
        check_output("held_btn_ticks", 32'(tick_total - base), 32'd1);
        check_output("held_btn_count", 32'(STEP_COUNT), 32'd1);

        // Long run: budget stops it after STEP_LIMIT ticks when enabled, otherwise it keeps going.
        SW0 = 1'b0;
        apply_reset();
        base = tick_total;
        SW0 = 1'b1;
        step(60);
        check_output("long_run_ticks", 32'(tick_total - base), 32'(LONG_TICKS));
`ifdef STEP_LIMIT_EN
        check_output("limit_pause_led", 32'(PAUSE_LED), 32'd1);
        base = tick_total;
        BTN0 = 1'b1;
        step(8);
        BTN0 = 1'b0;
        step(52);
        check_output("limit_resume_ticks", 32'(tick_total - base), 32'd3);
        check_output("limit_repause_led", 32'(PAUSE_LED), 32'd1);
`else
        check_output("long_run_led", 32'(RUN_LED), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
